mac_operand_seq: RTL and testbench

MAC_OPERAND_SEQ -- requirements
Module: mac_operand_seq

---
 rtl/mac_operand_seq.sv | 176 +++++++++++++++++
 tb/tb_mac_operand_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_seq.sv
// Operand sequencer for a dot-product MAC: streams A/B reads, drives the MAC
// operand/clear/next controls, and returns mac_psum through a valid/ready result.
// Optional feature: define MAC_OPERAND_SEQ_STRIDE_EN to add the b_stride port.
module mac_operand_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [8:0]  len,
  input  logic [9:0]  a_base,
  input  logic [9:0]  b_base,
`ifdef MAC_OPERAND_SEQ_STRIDE_EN
  input  logic [9:0]  b_stride,
`endif
  output logic        busy,
  output logic        mem_a_en,
  output logic        mem_b_en,
  output logic [9:0]  mem_a_addr,
  output logic [9:0]  mem_b_addr,
  input  logic [31:0] mem_a_rdata,
  input  logic [31:0] mem_b_rdata,
  output logic [31:0] mac_a,
  output logic [31:0] mac_b,
  output logic        mac_clear,
  output logic        mac_next,
  input  logic [64:0] mac_psum,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [64:0] res_data,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [8:0]  r_len;
  logic [8:0]  r_k;
  logic [2:0]  r_drain;
  logic [9:0]  r_a_addr;
  logic [9:0]  r_b_addr;
  logic [9:0]  w_stride;
  logic        r_clear;
  logic        r_rd_v1;
  logic        r_op_v;
  logic        r_nx_v3;
  logic        r_next;
  logic [31:0] r_mac_a;
  logic [31:0] r_mac_b;
  logic [64:0] r_res_data;
  logic        w_accept;
  logic        w_run;
  logic        w_capture;

`ifdef MAC_OPERAND_SEQ_STRIDE_EN
  logic [9:0]  r_stride;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stride <= 10'd0;
    end else if (w_accept) begin
      r_stride <= b_stride;
    end
  end

  assign w_stride = r_stride;
`else
  assign w_stride = 10'd1;
`endif

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_run     = (r_state == ST_RUN);
  assign w_capture = (r_state == ST_DRAIN) && (r_drain == 3'd4);

  // DRAIN spans five cycles so the last product has been accumulated
  // (read -> data -> operand reg -> MAC operand reg -> product reg -> acc).
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nx = (len == 9'd0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_k == (r_len - 9'd1)) begin
          w_state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain == 3'd4) begin
          w_state_nx = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_len    <= 9'd0;
      r_k      <= 9'd0;
      r_drain  <= 3'd0;
      r_a_addr <= 10'd0;
      r_b_addr <= 10'd0;
      r_clear  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_clear <= w_accept;
      r_k     <= w_run ? (r_k + 9'd1) : 9'd0;
      r_drain <= (r_state == ST_DRAIN) ? (r_drain + 3'd1) : 3'd0;
      if (w_accept) begin
        r_len    <= len;
        r_a_addr <= a_base;
        r_b_addr <= b_base;
      end else if (w_run) begin
        r_a_addr <= r_a_addr + 10'd1;
        r_b_addr <= r_b_addr + w_stride;
      end
    end
  end

  // Tag pipeline: read issued in c, data returns c+1, operand slot c+2,
  // next pulse c+4 aligned with the MAC's two internal registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_v1 <= 1'b0;
      r_op_v  <= 1'b0;
      r_nx_v3 <= 1'b0;
      r_next  <= 1'b0;
      r_mac_a <= 32'd0;
      r_mac_b <= 32'd0;
    end else begin
      r_rd_v1 <= w_run;
      r_op_v  <= r_rd_v1;
      r_nx_v3 <= r_op_v;
      r_next  <= r_nx_v3;
      r_mac_a <= r_rd_v1 ? mem_a_rdata : 32'd0;
      r_mac_b <= r_rd_v1 ? mem_b_rdata : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res_data <= 65'd0;
    end else if (w_capture) begin
      r_res_data <= mac_psum;
    end
  end

  // Result handshake: res_valid/res_data hold until a cycle with
  // res_valid=1 and res_ready=1; the transfer completes on that edge.
  assign busy        = (r_state != ST_IDLE);
  assign mem_a_en    = w_run;
  assign mem_b_en    = w_run;
  assign mem_a_addr  = w_run ? r_a_addr : 10'd0;
  assign mem_b_addr  = w_run ? r_b_addr : 10'd0;
  assign mac_a       = r_mac_a;
  assign mac_b       = r_mac_b;
  assign mac_clear   = r_clear;
  assign mac_next    = r_next;
  assign res_valid   = (r_state == ST_RESULT);
  assign res_data    = r_res_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_operand_seq.sv
// Bench for mac_operand_seq: memory and 64-bit-accumulator MAC models, directed
// runs, expected-queue scoreboard checked by a negedge monitor.
module tb_mac_operand_seq;

`ifdef MAC_OPERAND_SEQ_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  len = 9'd0;
  logic [9:0]  a_base = 10'd0;
  logic [9:0]  b_base = 10'd0;
`ifdef MAC_OPERAND_SEQ_STRIDE_EN
  logic [9:0]  b_stride = 10'd1;
`endif
  logic        busy, mem_a_en, mem_b_en, mac_clear, mac_next, res_valid;
  logic [9:0]  mem_a_addr, mem_b_addr;
  logic [31:0] mem_a_rdata = 32'd0, mem_b_rdata = 32'd0;
  logic [31:0] mac_a, mac_b;
  logic [64:0] mac_psum, res_data;
  logic        res_ready = 1'b1;
  logic [1:0]  o_dbg_state;

  mac_operand_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .a_base(a_base), .b_base(b_base),
`ifdef MAC_OPERAND_SEQ_STRIDE_EN
    .b_stride(b_stride),
`endif
    .busy(busy), .mem_a_en(mem_a_en), .mem_b_en(mem_b_en),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
    .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clear(mac_clear), .mac_next(mac_next),
    .mac_psum(mac_psum), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .o_dbg_state(o_dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous-read memories
  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];
  always @(posedge clk) begin
    if (mem_a_en) mem_a_rdata <= mem_a[mem_a_addr];
    if (mem_b_en) mem_b_rdata <= mem_b[mem_b_addr];
  end

  // downstream MAC: operand reg, product reg, 64-bit accumulator (psum[64]=0)
  logic [31:0] m_pa = 32'd0, m_pb = 32'd0;
  logic [63:0] m_prod = 64'd0, m_acc = 64'd0;
  always @(posedge clk) begin
    m_pa   <= mac_a;
    m_pb   <= mac_b;
    m_prod <= {32'd0, m_pa} * {32'd0, m_pb};
    if (mac_clear) m_acc <= 64'd0;
    else if (mac_next) m_acc <= m_acc + m_prod;
  end
  assign mac_psum = {1'b0, m_acc};

  // scoreboard
  int total = 0;
  int bad = 0;
  logic [51:0] exp_rd_q[$];
  logic [95:0] exp_op_q[$];
  logic [31:0] exp_nx_q[$];
  logic [31:0] exp_clr_q[$];
  logic [96:0] exp_res_q[$];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected event want none (cycle %0d)", name, cyc);
  endtask

  task automatic push_all(input int s, input int n, input int ab, input int bb, input int st,
                          input int n_rd, input int n_op, input int n_nx,
                          input bit with_res, input logic [64:0] exp_d);
    int est;
    logic [9:0] aa, ba;
    est = STRIDE_EN ? st : 1;
    exp_clr_q.push_back(32'(s + 1));
    for (int k = 0; k < n_rd; k++) begin
      aa = 10'((ab + k) % 1024);
      ba = 10'((bb + k * est) % 1024);
      exp_rd_q.push_back({32'(s + 1 + k), aa, ba});
    end
    for (int k = 0; k < n_op; k++) begin
      aa = 10'((ab + k) % 1024);
      ba = 10'((bb + k * est) % 1024);
      exp_op_q.push_back({32'(s + 3 + k), mem_a[aa], mem_b[ba]});
    end
    for (int k = 0; k < n_nx; k++) exp_nx_q.push_back(32'(s + 5 + k));
    if (with_res) exp_res_q.push_back({32'(s + n + 6), exp_d});
  endtask

  // monitor
  logic        prev_v = 1'b0;
  logic [51:0] m_rd;
  logic [95:0] m_op;
  logic [31:0] m_c;
  logic [96:0] m_res;
  always @(negedge clk) begin
    if (mem_a_en || mem_b_en) begin
      if (exp_rd_q.size() == 0) fail_evt("rd_unexpected");
      else begin
        m_rd = exp_rd_q.pop_front();
        check("rd_en_pair", {63'd0, mem_a_en, mem_b_en}, 65'd3);
        check("rd_cycle", 65'(cyc), 65'(m_rd[51:20]));
        check("rd_a_addr", 65'(mem_a_addr), 65'(m_rd[19:10]));
        check("rd_b_addr", 65'(mem_b_addr), 65'(m_rd[9:0]));
      end
    end
    if (mac_a != 32'd0 || mac_b != 32'd0) begin
      if (exp_op_q.size() == 0) fail_evt("op_unexpected");
      else begin
        m_op = exp_op_q.pop_front();
        check("op_cycle", 65'(cyc), 65'(m_op[95:64]));
        check("op_mac_a", 65'(mac_a), 65'(m_op[63:32]));
        check("op_mac_b", 65'(mac_b), 65'(m_op[31:0]));
      end
    end
    if (mac_next) begin
      if (exp_nx_q.size() == 0) fail_evt("next_unexpected");
      else begin
        m_c = exp_nx_q.pop_front();
        check("next_cycle", 65'(cyc), 65'(m_c));
      end
    end
    if (mac_clear) begin
      if (exp_clr_q.size() == 0) fail_evt("clear_unexpected");
      else begin
        m_c = exp_clr_q.pop_front();
        check("clear_cycle", 65'(cyc), 65'(m_c));
      end
    end
    if (res_valid && !prev_v) begin
      if (exp_res_q.size() == 0) fail_evt("res_unexpected");
      else check("res_first_cycle", 65'(cyc), 65'(exp_res_q[0][96:65]));
    end
    if (res_valid && res_ready && exp_res_q.size() != 0) begin
      m_res = exp_res_q.pop_front();
      check("res_data", res_data, m_res[64:0]);
    end
    prev_v = res_valid;
  end

  // driver tasks
  task automatic start_run(input int n, input int ab, input int bb, input int st, output int s);
    @(posedge clk); #1;
    s = cyc;
    len    = 9'(n);
    a_base = 10'(ab);
    b_base = 10'(bb);
`ifdef MAC_OPERAND_SEQ_STRIDE_EN
    b_stride = 10'(st);
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_handshake(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_evt({name, "_timeout"});
    @(negedge clk);
    check({name, "_after_busy"}, 65'(busy), 65'd0);
    check({name, "_after_valid"}, 65'(res_valid), 65'd0);
    check({name, "_after_state"}, 65'(o_dbg_state), 65'd0);
  endtask

  task automatic full_run(input string name, input int n, input int ab, input int bb,
                          input int st, input logic [64:0] exp_d);
    int s;
    start_run(n, ab, bb, st, s);
    push_all(s, n, ab, bb, st, n, n, n, 1'b1, exp_d);
    wait_handshake(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 65'(busy), 65'd0);
    check("rst_en", 65'({mem_a_en, mem_b_en}), 65'd0);
    check("rst_ctrl", 65'({mac_clear, mac_next, res_valid}), 65'd0);
    check("rst_state", 65'(o_dbg_state), 65'd0);
    check("rst_res_data", res_data, 65'd0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // N=4 basic dot product
    for (int i = 0; i < 4; i++) begin
      mem_a[i]       = 32'(i + 1);
      mem_b[100 + i] = 32'(i + 5);
    end
    full_run("n4", 4, 0, 100, 1, 65'd70);

    // N=0: no reads, result 0
    full_run("n0", 0, 0, 0, 1, 65'd0);

    // N=256 all ones: 256*(2^32-1)^2 kept to 64 bits
    for (int i = 0; i < 256; i++) begin
      mem_a[i]       = 32'hFFFF_FFFF;
      mem_b[512 + i] = 32'hFFFF_FFFF;
    end
    full_run("n256", 256, 0, 512, 1, 65'h0_FFFF_FE00_0000_0100);

    // address wrap on A; B strided when enabled
    for (int i = 0; i < 4; i++) begin
      mem_a[1020 + i] = 32'(i + 1);
      mem_a[i]        = 32'(i + 5);
    end
    for (int j = 0; j < 16; j++) mem_b[300 + j] = 32'(j + 1);
    full_run("wrap", 8, 1020, 300, 2, STRIDE_EN ? 65'd372 : 65'd204);
    if (STRIDE_EN) full_run("stride0", 3, 1020, 300, 0, 65'd6);

    // consumer stall with ignored start; start on handshake cycle ignored
    mem_a[10] = 32'd3;
    mem_a[11] = 32'd4;
    mem_b[20] = 32'd10;
    mem_b[21] = 32'd20;
    res_ready = 1'b0;
    start_run(2, 10, 20, 1, s);
    push_all(s, 2, 10, 20, 1, 2, 2, 2, 1'b1, 65'd110);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    check("stall_valid", 65'(res_valid), 65'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start = (i == 4);
      @(negedge clk);
      check("stall_hold_valid", 65'(res_valid), 65'd1);
      check("stall_hold_busy", 65'(busy), 65'd1);
      check("stall_hold_data", res_data, 65'd110);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("hs_start_busy", 65'(busy), 65'd0);
    check("hs_start_state", 65'(o_dbg_state), 65'd0);
    repeat (3) @(negedge clk);

    // reset in the middle of RUN at k=3
    start_run(8, 1020, 300, 1, s);
    push_all(s, 8, 1020, 300, 1, 3, 1, 0, 1'b0, 65'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 65'(busy), 65'd0);
    check("mid_rst_en", 65'({mem_a_en, mem_b_en}), 65'd0);
    check("mid_rst_addr", 65'({mem_a_addr, mem_b_addr}), 65'd0);
    check("mid_rst_ops", 65'({mac_a, mac_b}), 65'd0);
    check("mid_rst_ctrl", 65'({mac_clear, mac_next, res_valid}), 65'd0);
    check("mid_rst_res_data", res_data, 65'd0);
    check("mid_rst_state", 65'(o_dbg_state), 65'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_busy", 65'(busy), 65'd0);
    full_run("post_rst", 2, 10, 20, 1, 65'd110);

    repeat (4) @(negedge clk);
    check("q_rd_empty", 65'(exp_rd_q.size()), 65'd0);
    check("q_op_empty", 65'(exp_op_q.size()), 65'd0);
    check("q_next_empty", 65'(exp_nx_q.size()), 65'd0);
    check("q_clear_empty", 65'(exp_clr_q.size()), 65'd0);
    check("q_res_empty", 65'(exp_res_q.size()), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
